iram_port_arbiter: RTL and testbench
====================================

// Module: iram_port_arbiter
// PURPOSE
//  Shares the single-port instruction RAM (byte-strobed write, 1-cycle registered read) between two
//  requesters: the CPU fetch port (read-only) and the debug/program loader (read/write).
//  Sits between the core's IF stage, the loader, and the RAM's wea/addra/dina/douta pins.
//  Issues at most one RAM access per cycle and steers the returned read data.
// PARAMETERS
//  ADDR_W      12   RAM word-address width (4096 words max)
//  STARVE_MAX  8    consecutive denied loader cycles before a forced loader grant (IRAM_ARB_STARVE_GUARD_EN only)
// PORTS
//  clk        in   1       clock; all state updates on its rising edge
//  rst_n      in   1       asynchronous reset, active-low
//  if_req     in   1       fetch read request
//  if_addr    in   ADDR_W  fetch word address
//  if_gnt     out  1       fetch access issued this cycle (combinational)
//  if_rvalid  out  1       if_rdata valid; registered, 1 cycle after if_gnt
//  if_rdata   out  32      read data; equals ram_douta
//  ld_req     in   1       loader request
//  ld_we      in   4       loader byte write strobes; 4'b0000 means read
//  ld_addr    in   ADDR_W  loader word address
//  ld_wdata   in   32      loader write data
//  ld_lock    in   1       loader requests exclusive ownership after its next grant
//  ld_gnt     out  1       loader access issued this cycle (combinational)
//  ld_rvalid  out  1       ld_rdata valid; only for reads (ld_we==0), 1 cycle after ld_gnt
//  ld_rdata   out  32      read data; equals ram_douta
//  ram_wea    out  4       to RAM; ld_we when ld_gnt, else 4'b0000
//  ram_addra  out  ADDR_W  to RAM; address of the granted requester, else if_addr
//  ram_dina   out  32      to RAM; ld_wdata
//  ram_douta  in   32      from RAM; registered read data
// BEHAVIOUR
//  - Reset (rst_n low, asynchronous): state=ARB, if_rvalid=0, ld_rvalid=0, starvation count=0.
//    While reset is held, if_gnt=ld_gnt=0 and ram_wea=0. An in-flight read is dropped, with no rvalid.
//  - if_gnt and ld_gnt are mutually exclusive. A request is accepted in the cycle its gnt is high.
//    The requester must hold req/addr/we/wdata stable until gnt.
//  - FSM state ARB: fixed priority, fetch first.
//    if_gnt = if_req & ~force_ld; ld_gnt = ld_req & (~if_req | force_ld).
//  - ARB -> LOCK when ld_gnt & ld_lock.
//  - FSM state LOCK: if_gnt=0; ld_gnt=ld_req.
//    LOCK -> ARB on the first cycle ld_lock is sampled low. That cycle is arbitrated as ARB.
//  - Read return: if_rvalid <= if_gnt; ld_rvalid <= ld_gnt & (ld_we==0). Latency is exactly 1 cycle.
//    Back-to-back grants produce back-to-back rvalids.
//  - Writes complete at the clock edge of the grant, with no response.
//    A read in the next cycle to the same address returns the new data.
//  - No request pending: ram_wea=0, ram_addra=if_addr. The RAM performs a harmless read.
//  - Addresses are taken modulo 2^ADDR_W. There is no range check.
// CONFIGURATION
//  IRAM_ARB_STARVE_GUARD_EN defined:
//    - The counter increments each cycle ld_req & ~ld_gnt and saturates at STARVE_MAX.
//    - The counter clears on ld_gnt or when ld_req is low.
//    - force_ld = (count==STARVE_MAX). It asserts ld_gnt for one access; fetch is denied that cycle.
//  IRAM_ARB_STARVE_GUARD_EN undefined:
//    - force_ld=0 and the counter is absent.
//    - The loader is served only when fetch is idle, or in LOCK.
// STRUCTURE
//  - Package iram_arb_pkg holds:
//    - typedef enum logic {ARB, LOCK} arb_state_t
//    - localparam IRAM_DATA_W=32
//    - localparam IRAM_STRB_W=4
//  - Sub-module iram_starve_ctr holds the saturating counter. It is instantiated only under the macro.
// TESTING
//  1. Reset mid-read: if_req=1 with if_addr=5, assert rst_n=0 in the rvalid cycle.
//     -> if_rvalid drops to 0 immediately; after release, the first grant is in ARB.
//  2. Contention: if_req=1 and ld_req=1 (read, addr 0x010) for 3 cycles.
//     -> if_gnt=1 each cycle, ld_gnt=0; if_rvalid=1 on cycles 2..4.
//  3. Loader write then read: ld_we=4'b0011, addr 0x020, wdata 0xAABBCCDD, over old value 0x11223344;
//     then ld_we=0 at the same address.
//     -> ld_rvalid=1 one cycle later with ld_rdata=0x1122CCDD.
//  4. Lock: ld_lock=1 with ld_req=1 while if_req=1.
//     -> after the first ld_gnt, if_gnt stays 0 for every LOCK cycle.
//     -> drop ld_lock; if_gnt=1 in that same cycle.
//  5. Guard (macro on, STARVE_MAX=8): if_req and ld_req held high continuously.
//     -> ld_gnt=1 on cycle 9, if_gnt=0 that cycle, then the pattern repeats.
//  6. Guard off: same stimulus as test 5 for 64 cycles.
//     -> ld_gnt never asserts.

Source files
------------

// File: rtl/iram_arb_pkg.sv
// Shared types and widths for the instruction-RAM port arbiter.
package iram_arb_pkg;

  typedef enum logic {ARB, LOCK} arb_state_t;

  localparam int unsigned IRAM_DATA_W = 32;
  localparam int unsigned IRAM_STRB_W = 4;

endpackage

// File: rtl/iram_starve_ctr.sv
// Saturating count of consecutive loader cycles spent waiting; raises force_ld once the
// count reaches STARVE_MAX so the next loader access pre-empts fetch.
module iram_starve_ctr #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_req,
  input  logic ld_gnt,
  output logic force_ld
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!ld_req || ld_gnt) begin
      count <= '0;
    end else if (count != CNT_MAX) begin
      count <= count + 1'b1;
    end
  end

  assign force_ld = (count == CNT_MAX);

endmodule

// File: rtl/iram_port_arbiter.sv
// Shares the single-port instruction RAM between CPU fetch (read-only) and the loader (read/write).
// Optional starvation guard for the loader is enabled by defining IRAM_ARB_STARVE_GUARD_EN.
module iram_port_arbiter
  import iram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_req,
  input  logic [ADDR_W-1:0]      if_addr,
  output logic                   if_gnt,
  output logic                   if_rvalid,
  output logic [IRAM_DATA_W-1:0] if_rdata,
  input  logic                   ld_req,
  input  logic [IRAM_STRB_W-1:0] ld_we,
  input  logic [ADDR_W-1:0]      ld_addr,
  input  logic [IRAM_DATA_W-1:0] ld_wdata,
  input  logic                   ld_lock,
  output logic                   ld_gnt,
  output logic                   ld_rvalid,
  output logic [IRAM_DATA_W-1:0] ld_rdata,
  output logic [IRAM_STRB_W-1:0] ram_wea,
  output logic [ADDR_W-1:0]      ram_addra,
  output logic [IRAM_DATA_W-1:0] ram_dina,
  input  logic [IRAM_DATA_W-1:0] ram_douta
);

  if (STARVE_MAX < 1) begin : g_starve_max_chk
    $error("iram_port_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_t state;
  logic       lock_mode;
  logic       force_ld;

`ifdef IRAM_ARB_STARVE_GUARD_EN
  iram_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_req  (ld_req),
    .ld_gnt  (ld_gnt),
    .force_ld(force_ld)
  );
`else
  assign force_ld = 1'b0;
`endif

  // The cycle ld_lock is seen low in LOCK is already arbitrated with fetch priority.
  assign lock_mode = (state == LOCK) && ld_lock;

  always_comb begin
    if_gnt = 1'b0;
    ld_gnt = 1'b0;
    if (rst_n) begin
      if (lock_mode) begin
        ld_gnt = ld_req;
      end else begin
        if_gnt = if_req & ~force_ld;
        ld_gnt = ld_req & (~if_req | force_ld);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      if_rvalid <= 1'b0;
      ld_rvalid <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      ld_rvalid <= ld_gnt & (ld_we == '0);
      unique case (state)
        ARB:     if (ld_gnt && ld_lock) state <= LOCK;
        LOCK:    if (!ld_lock)          state <= ARB;
        default:                        state <= ARB;
      endcase
    end
  end

  assign ram_wea   = ld_gnt ? ld_we : '0;
  assign ram_addra = ld_gnt ? ld_addr : if_addr;
  assign ram_dina  = ld_wdata;
  assign if_rdata  = ram_douta;
  assign ld_rdata  = ram_douta;

endmodule

// File: tb/tb_iram_port_arbiter.sv
// Randomized and directed bench for iram_port_arbiter with a behavioural RAM and reference model.
module tb_iram_port_arbiter;
  import iram_arb_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned SMAX  = 8;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef IRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          ld_req;
  logic [3:0]    ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_lock;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [31:0]   ld_rdata;
  logic [3:0]    ram_wea;
  logic [AW-1:0] ram_addra;
  logic [31:0]   ram_dina;
  logic [31:0]   ram_douta;

  iram_port_arbiter #(
    .ADDR_W    (AW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .ld_req   (ld_req),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_wdata (ld_wdata),
    .ld_lock  (ld_lock),
    .ld_gnt   (ld_gnt),
    .ld_rvalid(ld_rvalid),
    .ld_rdata (ld_rdata),
    .ram_wea  (ram_wea),
    .ram_addra(ram_addra),
    .ram_dina (ram_dina),
    .ram_douta(ram_douta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: byte-strobed write, registered read.
  logic [31:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    logic [31:0] w;
    w = mem[ram_addra];
    for (int b = 0; b < 4; b++)
      if (ram_wea[b]) w[8*b +: 8] = ram_dina[8*b +: 8];
    if (ram_wea != 4'b0) mem[ram_addra] <= w;
    ram_douta <= mem[ram_addra];
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  logic [31:0] ref_mem [0:DEPTH-1];
  bit          ref_ok  [0:DEPTH-1];
  bit          m_locked;
  int unsigned m_denied;
  bit          m_if_g, m_ld_g;
  bit          exp_if_rv, exp_ld_rv, exp_known;
  logic [31:0] exp_rdata;

  // DUT values captured at the last sampling point
  logic        cap_if_gnt, cap_ld_gnt, cap_if_rv, cap_ld_rv;
  logic [31:0] cap_ld_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    m_locked  = 1'b0;
    m_denied  = 0;
    exp_if_rv = 1'b0;
    exp_ld_rv = 1'b0;
    exp_known = 1'b0;
    m_if_g    = 1'b0;
    m_ld_g    = 1'b0;
  endtask

  // Called just after a rising edge with inputs applied; samples at the falling edge,
  // advances the model, and returns 1 time unit after the next rising edge.
  task automatic cycle();
    bit          eg_if, eg_ld, excl, frc;
    logic [AW-1:0] a;
    @(negedge clk);
    excl  = m_locked && ld_lock;
    frc   = GUARD && (m_denied == SMAX);
    eg_if = 1'b0;
    eg_ld = 1'b0;
    if (rst_n) begin
      if (excl) eg_ld = ld_req;
      else if (ld_req && (!if_req || frc)) eg_ld = 1'b1;
      else eg_if = if_req;
    end
    a = eg_ld ? ld_addr : if_addr;
    check("if_gnt", 32'(if_gnt), 32'(eg_if));
    check("ld_gnt", 32'(ld_gnt), 32'(eg_ld));
    check("ram_wea", 32'(ram_wea), eg_ld ? 32'(ld_we) : 32'h0);
    check("ram_addra", 32'(ram_addra), 32'(a));
    check("if_rvalid", 32'(if_rvalid), 32'(exp_if_rv));
    check("ld_rvalid", 32'(ld_rvalid), 32'(exp_ld_rv));
    if (exp_if_rv && exp_known) check("if_rdata", if_rdata, exp_rdata);
    if (exp_ld_rv && exp_known) check("ld_rdata", ld_rdata, exp_rdata);
    cap_if_gnt   = if_gnt;
    cap_ld_gnt   = ld_gnt;
    cap_if_rv    = if_rvalid;
    cap_ld_rv    = ld_rvalid;
    cap_ld_rdata = ld_rdata;
    if (!rst_n) begin
      reset_model();
    end else begin
      exp_if_rv = eg_if;
      exp_ld_rv = eg_ld && (ld_we == 4'b0);
      exp_rdata = ref_mem[a];
      exp_known = ref_ok[a];
      if (eg_ld && ld_we != 4'b0) begin
        for (int b = 0; b < 4; b++)
          if (ld_we[b]) ref_mem[a][8*b +: 8] = ld_wdata[8*b +: 8];
        ref_ok[a] = ref_ok[a] || (ld_we == 4'hF);
      end
      m_locked = ld_lock && (m_locked || eg_ld);
      if (!ld_req || eg_ld) m_denied = 0;
      else if (m_denied < SMAX) m_denied++;
      m_if_g = eg_if;
      m_ld_g = eg_ld;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pick_inputs();
    if (!if_req || m_if_g) begin
      if_req  = ($urandom_range(0, 99) < 55);
      if_addr = AW'($urandom_range(0, 31));
    end
    if (!ld_req || m_ld_g) begin
      ld_req   = ($urandom_range(0, 99) < 40);
      ld_addr  = AW'($urandom_range(0, 31));
      ld_we    = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(1, 15));
      ld_wdata = $urandom();
    end
    ld_lock = m_locked ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 24) == 0);
  endtask

  initial begin
    rst_n = 1'b0;  if_req = 1'b0; if_addr = '0;
    ld_req = 1'b0; ld_we = 4'h0;  ld_addr = '0; ld_wdata = '0; ld_lock = 1'b0;
    reset_model();
    #1;
    check("rst_if_gnt", 32'(if_gnt), 32'h0);
    check("rst_ram_wea", 32'(ram_wea), 32'h0);
    cycle();
    cycle();
    rst_n = 1'b1;

    // Reset during the read-return cycle drops the pending rvalid.
    if_req = 1'b1; if_addr = AW'(5);
    cycle();
    check("t1_rvalid_before_rst", 32'(if_rvalid), 32'h1);
    if_req = 1'b0; ld_req = 1'b1; ld_we = 4'hF; ld_addr = AW'(7); ld_wdata = 32'hDEADBEEF;
    rst_n = 1'b0;
    #1;
    check("t1_rvalid_in_rst", 32'(if_rvalid), 32'h0);
    check("t1_ld_gnt_in_rst", 32'(ld_gnt), 32'h0);
    check("t1_wea_in_rst", 32'(ram_wea), 32'h0);
    reset_model();
    cycle();
    rst_n = 1'b1;
    if_req = 1'b1; ld_req = 1'b1; ld_we = 4'h0; ld_lock = 1'b1;
    cycle();
    check("t1_first_gnt_arb_if", 32'(cap_if_gnt), 32'h1);
    check("t1_first_gnt_arb_ld", 32'(cap_ld_gnt), 32'h0);
    if_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0;
    cycle();

    // Preload a small window so random reads have known contents.
    for (int unsigned i = 0; i < 32; i++) begin
      ld_req = 1'b1; ld_we = 4'hF; ld_addr = AW'(i); ld_wdata = $urandom();
      cycle();
    end
    ld_req = 1'b0;
    cycle();

    // Contention: fetch wins, rvalid follows each grant.
    if_req = 1'b1; ld_req = 1'b1; ld_we = 4'h0; ld_addr = AW'(12'h010);
    for (int unsigned i = 1; i <= 3; i++) begin
      if_addr = AW'(i);
      cycle();
      check("t2_if_gnt", 32'(cap_if_gnt), 32'h1);
      check("t2_ld_gnt", 32'(cap_ld_gnt), 32'h0);
      if (i >= 2) check("t2_if_rvalid", 32'(cap_if_rv), 32'h1);
    end
    if_req = 1'b0;
    cycle();
    check("t2_if_rvalid_last", 32'(cap_if_rv), 32'h1);
    ld_req = 1'b0;
    cycle();

    // Partial write merges with the old word.
    ld_req = 1'b1; ld_addr = AW'(12'h020); ld_we = 4'hF; ld_wdata = 32'h11223344;
    cycle();
    ld_we = 4'b0011; ld_wdata = 32'hAABBCCDD;
    cycle();
    check("t3_write_no_rvalid", 32'(ld_rvalid), 32'h0);
    ld_we = 4'h0;
    cycle();
    ld_req = 1'b0;
    cycle();
    check("t3_ld_rvalid", 32'(cap_ld_rv), 32'h1);
    check("t3_ld_rdata", cap_ld_rdata, 32'h1122CCDD);

    // Lock: fetch is shut out until ld_lock drops.
    ld_req = 1'b1; ld_lock = 1'b1; ld_we = 4'h0; ld_addr = AW'(3);
    cycle();
    check("t4_first_ld_gnt", 32'(cap_ld_gnt), 32'h1);
    if_req = 1'b1; if_addr = AW'(9);
    for (int unsigned i = 0; i < 4; i++) begin
      cycle();
      check("t4_lock_if_gnt", 32'(cap_if_gnt), 32'h0);
      check("t4_lock_ld_gnt", 32'(cap_ld_gnt), 32'h1);
    end
    ld_lock = 1'b0;
    cycle();
    check("t4_unlock_if_gnt", 32'(cap_if_gnt), 32'h1);
    if_req = 1'b0; ld_req = 1'b0;
    cycle();

    // Continuous contention: guard forces every ninth loader grant, else loader starves.
    if_req = 1'b1; ld_req = 1'b1; ld_we = 4'h0; ld_addr = AW'(4); if_addr = AW'(6);
`ifdef IRAM_ARB_STARVE_GUARD_EN
    for (int unsigned i = 1; i <= 18; i++) begin
      cycle();
      check("t5_ld_gnt", 32'(cap_ld_gnt), (i % 9 == 0) ? 32'h1 : 32'h0);
      check("t5_if_gnt", 32'(cap_if_gnt), (i % 9 == 0) ? 32'h0 : 32'h1);
    end
`else
    for (int unsigned i = 1; i <= 64; i++) begin
      cycle();
      check("t6_ld_gnt", 32'(cap_ld_gnt), 32'h0);
    end
`endif
    if_req = 1'b0; ld_req = 1'b0;
    cycle();
    if (!m_ld_g) begin
      ld_req = 1'b1;
      cycle();
    end
    ld_req = 1'b0;
    cycle();

    // Random traffic against the reference model.
    for (int unsigned i = 0; i < 800; i++) begin
      pick_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
